// File: rtl/recepcao_pesos.sv
// -----------------------------------------------------------------------------
// recepcao_pesos
//   8N1 serial receiver plus weight-frame assembler. A frame is six ASCII
//   digits followed by '#'. When a complete valid frame arrives, the six digits
//   are published on valor_reg and fimRecepcao pulses for one cycle. Any bad
//   character, framing error or early '#' discards the partial frame and
//   pulses erroRecepcao for one cycle instead.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   entrada_serial asynchronous UART line, idles high
//   valor_reg      last valid frame; byte k (k=0 first) at [47-8k:40-8k]
//   fimRecepcao    one-cycle pulse, valor_reg just updated
//   erroRecepcao   one-cycle pulse, frame discarded
//   db_estado      current RX FSM state
//   db_indice      current frame character index (0..6)
// -----------------------------------------------------------------------------
module recepcao_pesos #(
  parameter int CICLOS_POR_BIT = 434,
  parameter int LARGURA_CONT   = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [47:0] valor_reg,
  output logic        fimRecepcao,
  output logic        erroRecepcao,
  output logic [3:0]  db_estado,
  output logic [2:0]  db_indice
);

  // Last count value of a full bit period and of a half bit period.
  localparam logic [LARGURA_CONT-1:0] FIM_BIT  = LARGURA_CONT'(CICLOS_POR_BIT - 1);
  localparam logic [LARGURA_CONT-1:0] FIM_MEIO = LARGURA_CONT'(CICLOS_POR_BIT / 2 - 1);

  typedef enum logic [3:0] {
    OCIOSO      = 4'd0,
    START       = 4'd1,
    DADOS       = 4'd2,
    STOP        = 4'd3,
    BYTE_OK     = 4'd4,
    ERRO_QUADRO = 4'd5
  } estado_t;

  estado_t                 estado;
  logic                    sinc_a;
  logic                    sinc_b;
  logic                    linha;
  logic [LARGURA_CONT-1:0] cont;
  logic [2:0]              nbits;
  logic [7:0]              desloc;
  logic                    erro_pend;
  logic [2:0]              indice;
  logic [7:0]              sombra [0:5];
  logic                    digito;

  assign linha     = sinc_b;
  assign digito    = (desloc >= 8'h30) && (desloc <= 8'h39);
  assign db_estado = estado;
  assign db_indice = indice;

  always_ff @(posedge clock) begin
    if (reset) begin
      sinc_a       <= 1'b1;
      sinc_b       <= 1'b1;
      estado       <= OCIOSO;
      cont         <= '0;
      nbits        <= '0;
      desloc       <= '0;
      erro_pend    <= 1'b0;
      indice       <= '0;
      valor_reg    <= '0;
      fimRecepcao  <= 1'b0;
      erroRecepcao <= 1'b0;
      for (int i = 0; i < 6; i++) sombra[i] <= '0;
    end else begin
      sinc_a       <= entrada_serial;
      sinc_b       <= sinc_a;
      fimRecepcao  <= 1'b0;
      erroRecepcao <= 1'b0;

      case (estado)
        OCIOSO: begin
          if (!linha) begin
            estado <= START;
            cont   <= '0;
          end
        end

        // Wait half a bit and re-check: a line that is high again was a glitch.
        START: begin
          if (cont == FIM_MEIO) begin
            cont   <= '0;
            nbits  <= '0;
            estado <= linha ? OCIOSO : DADOS;
          end else begin
            cont <= cont + LARGURA_CONT'(1);
          end
        end

        // Samples land mid-bit because the counter was phased by START.
        DADOS: begin
          if (cont == FIM_BIT) begin
            cont   <= '0;
            desloc <= {linha, desloc[7:1]};
            nbits  <= nbits + 3'd1;
            if (nbits == 3'd7) estado <= STOP;
          end else begin
            cont <= cont + LARGURA_CONT'(1);
          end
        end

        STOP: begin
          if (cont == FIM_BIT) begin
            cont <= '0;
            if (linha) begin
              estado <= BYTE_OK;
            end else begin
              estado    <= ERRO_QUADRO;
              erro_pend <= 1'b1;
            end
          end else begin
            cont <= cont + LARGURA_CONT'(1);
          end
        end

        // Frame assembler step for a correctly framed byte.
        BYTE_OK: begin
          estado <= OCIOSO;
          if ((indice < 3'd6) && digito) begin
            sombra[indice] <= desloc;
            indice         <= indice + 3'd1;
          end else if ((indice == 3'd6) && (desloc == 8'h23)) begin
            valor_reg   <= {sombra[0], sombra[1], sombra[2],
                            sombra[3], sombra[4], sombra[5]};
            fimRecepcao <= 1'b1;
            indice      <= '0;
          end else begin
            indice       <= '0;
            erroRecepcao <= 1'b1;
          end
        end

        // A break can hold the line low for a long time; the error is reported
        // once on entry (erro_pend) and the FSM waits for the line to go idle.
        ERRO_QUADRO: begin
          if (erro_pend) begin
            erro_pend    <= 1'b0;
            indice       <= '0;
            erroRecepcao <= 1'b1;
          end
          if (linha) estado <= OCIOSO;
        end

        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_recepcao_pesos.sv
// -----------------------------------------------------------------------------
// tb_recepcao_pesos
//   Directed plus randomized frames driven serially into recepcao_pesos with a
//   frame-level reference model of the assembler rules.
// -----------------------------------------------------------------------------
module tb_recepcao_pesos;

  localparam int CPB    = 16;
  localparam int LC     = 5;
  localparam int PERIOD = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        entrada_serial;
  logic [47:0] valor_reg;
  logic        fimRecepcao;
  logic        erroRecepcao;
  logic [3:0]  db_estado;
  logic [2:0]  db_indice;

  recepcao_pesos #(.CICLOS_POR_BIT(CPB), .LARGURA_CONT(LC)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .valor_reg      (valor_reg),
    .fimRecepcao    (fimRecepcao),
    .erroRecepcao   (erroRecepcao),
    .db_estado      (db_estado),
    .db_indice      (db_indice)
  );

  // ---------------- clock / watchdog ----------------
  always #(PERIOD / 2) clock = ~clock;

  initial begin
    #(3_000_000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  int          fim_seen = 0;
  int          err_seen = 0;
  bit          saw_estado5 = 1'b0;
  bit          saw_start   = 1'b0;
  longint      fim_t_last  = 0;
  longint      fim_t_prev  = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_exp;

  // Reference model state: frame-level view of the assembler.
  logic [7:0]  m_sombra [6];
  int          m_idx   = 0;
  logic [47:0] m_valor = '0;
  int          exp_fim = 0;
  int          exp_err = 0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: pulse counting, exclusivity, value carried with fim.
  always @(negedge clock) begin
    if (db_estado == 4'd5) saw_estado5 = 1'b1;
    if (db_estado == 4'd1) saw_start = 1'b1;
    if (fimRecepcao === 1'b1) begin
      fim_seen++;
      fim_t_prev = fim_t_last;
      fim_t_last = longint'($time);
      if (exp_q.size() == 0) begin
        check("fim_unexpected", 48'(fimRecepcao), 48'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("valor_at_fim", valor_reg, mon_exp);
      end
    end
    if (erroRecepcao === 1'b1) err_seen++;
    if ((fimRecepcao === 1'b1) || (erroRecepcao === 1'b1))
      check("pulses_exclusive", 48'(fimRecepcao & erroRecepcao), 48'(0));
  end

  // ---------------- reference model ----------------
  task automatic model_char(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      m_idx = 0;
      exp_err++;
    end else if ((m_idx < 6) && (b >= 8'h30) && (b <= 8'h39)) begin
      m_sombra[m_idx] = b;
      m_idx++;
    end else if ((m_idx == 6) && (b == 8'h23)) begin
      for (int k = 0; k < 6; k++) m_valor[47 - 8 * k -: 8] = m_sombra[k];
      exp_q.push_back(m_valor);
      exp_fim++;
      m_idx = 0;
    end else begin
      m_idx = 0;
      exp_err++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_bit(input logic v);
    entrada_serial = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_char(input logic [7:0] b, input bit stop_ok);
    model_char(b, stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);
    check("fim_count", 48'(fim_seen), 48'(exp_fim));
    check("err_count", 48'(err_seen), 48'(exp_err));
    check("db_indice", 48'(db_indice), 48'(m_idx));
    check("valor_reg", valor_reg, m_valor);
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valor"}, valor_reg, 48'h0);
    check({tag, "_fim"}, 48'(fimRecepcao), 48'(0));
    check({tag, "_err"}, 48'(erroRecepcao), 48'(0));
    check({tag, "_estado"}, 48'(db_estado), 48'(0));
    check({tag, "_indice"}, 48'(db_indice), 48'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int          mode;
    int          pos;
    logic [7:0]  b;
    bit          stop_ok;

    entrada_serial = 1'b1;
    reset          = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_values("reset_initial");
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Valid frame.
    send_string("123045#");
    check("t1_valor_const", valor_reg, 48'h313233303435);

    // Bad character, then early '#'.
    send_string("12A045#");
    check("t2_valor_kept", valor_reg, 48'h313233303435);

    // Framing error on the 5th character, then a fresh valid frame.
    send_string("1230");
    saw_estado5 = 1'b0;
    send_char(8'h34, 1'b0);
    check("t3_saw_erro_quadro", 48'(saw_estado5), 48'(1));
    send_string("987654#");
    check("t3_valor_const", valor_reg, 48'h393837363534);

    // Short low glitch on an idle line.
    saw_start      = 1'b0;
    entrada_serial = 1'b0;
    repeat (4) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    check("t4_saw_start", 48'(saw_start), 48'(1));
    check("t4_estado_idle", 48'(db_estado), 48'(0));
    check("t4_indice", 48'(db_indice), 48'(m_idx));
    check("t4_fim_count", 48'(fim_seen), 48'(exp_fim));
    check("t4_err_count", 48'(err_seen), 48'(exp_err));

    // Reset in the middle of a frame.
    send_string("555");
    reset = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    m_idx   = 0;
    m_valor = '0;
    check_reset_values("t5_reset");
    repeat (2) @(negedge clock);
    send_string("010203#");
    check("t5_valor_const", valor_reg, 48'h303130323033);

    // Back-to-back frames: pulses exactly 7 character times apart.
    send_string("111111#222222#");
    check("t6_valor_const", valor_reg, 48'h323232323232);
    check("t6_pulse_spacing", 48'(fim_t_last - fim_t_prev), 48'(7 * 10 * CPB * PERIOD));

    // Randomized frames: valid, corrupted byte, or framing error.
    for (int f = 0; f < 8; f++) begin
      mode = int'($urandom_range(0, 3));
      pos  = int'($urandom_range(0, 6));
      for (int c = 0; c < 7; c++) begin
        b       = (c < 6) ? 8'(8'h30 + $urandom_range(0, 9)) : 8'h23;
        stop_ok = 1'b1;
        if ((mode == 1) && (c == pos)) b = 8'($urandom_range(0, 255));
        if ((mode == 2) && (c == pos)) stop_ok = 1'b0;
        send_char(b, stop_ok);
      end
    end

    repeat (2 * CPB) @(negedge clock);
    check("final_queue_empty", 48'(exp_q.size()), 48'(0));
    check("final_fim_count", 48'(fim_seen), 48'(exp_fim));
    check("final_err_count", 48'(err_seen), 48'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recepcao_pesos.md
Name: recepcao_pesos

Overview:
- Serial receiver and frame assembler that directly feeds the gate controller datapath.
- Receives 8N1 UART characters on entrada_serial and validates a 7-character weight frame: six ASCII digits followed by '#'.
- On a valid frame, publishes the digits as the 48-bit valor_reg word and pulses fimRecepcao.
- Downstream consumers extract pesoMax, pesoMin and pesoAtual from the low nibble of each byte.

Parameters:
- CICLOS_POR_BIT, 434: clock cycles per serial bit (50 MHz / 115200 baud); must be >= 4.
- LARGURA_CONT, 9: width of the bit-timing counter; must satisfy 2^LARGURA_CONT > CICLOS_POR_BIT.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- entrada_serial  input  1  asynchronous UART line; idles high.
- valor_reg  output  48  last valid frame; byte k (k=0 first received) at bits [47-8k:40-8k].
- fimRecepcao  output  1  one-cycle pulse when valor_reg has just been updated.
- erroRecepcao  output  1  one-cycle pulse when a frame is discarded.
- db_estado  output  4  encoding of the current RX FSM state.
- db_indice  output  3  current frame character index, 0..6.

Behaviour:
- Reset values: valor_reg=0, fimRecepcao=0, erroRecepcao=0, db_estado=0, db_indice=0; shadow buffer cleared; synchronizer flops set to 1.
- Reset is synchronous and active-high. Asserting it mid-character or mid-frame aborts all activity; no pulse is generated.
- entrada_serial passes through a 2-flop synchronizer. All references below use the synchronized value.
- RX FSM states and transitions:
  - OCIOSO(0): on line=0, go to START and clear the counter.
  - START(1): count to CICLOS_POR_BIT/2 (integer division). If line=0, go to DADOS with bit count 0; if line=1 (glitch), return to OCIOSO silently.
  - DADOS(2): every CICLOS_POR_BIT cycles, sample the line into the shift register, LSB first. After the 8th sample, go to STOP.
  - STOP(3): after CICLOS_POR_BIT cycles, sample the line. 1 -> BYTE_OK; 0 -> ERRO_QUADRO.
  - BYTE_OK(4): one cycle; hand the byte to the assembler, then go to OCIOSO.
  - ERRO_QUADRO(5): one cycle; signal a framing error to the assembler; then go to OCIOSO only once line=1 (stays in ERRO_QUADRO while line=0, i.e. during a break).
- Frame assembler (acts in the BYTE_OK / ERRO_QUADRO cycle):
  - indice<6 and byte in 0x30..0x39: store into shadow slot indice; indice+1.
  - indice=6 and byte=0x23 ('#'): valor_reg <= shadow; indice=0.
  - Any other byte, any framing error, or '#' at indice<6: indice=0, shadow discarded, valor_reg unchanged.
- Output timing:
  - fimRecepcao is high for exactly the one cycle after the BYTE_OK cycle of '#'. valor_reg takes its new value on the same edge, so it is stable while fimRecepcao=1.
  - erroRecepcao is high for exactly the one cycle after the rejecting cycle.
  - fimRecepcao and erroRecepcao are never high together.
- Total latency: valid frame from the '#' stop-bit sample to fimRecepcao = 2 cycles (BYTE_OK plus register).
- valor_reg holds its value indefinitely between valid frames. Back-to-back frames with no idle gap beyond the stop bit must be accepted.

Test Plan:
- CICLOS_POR_BIT=16; send "123045#" -> one fimRecepcao pulse; valor_reg=48'h313233303435; erroRecepcao stays 0; db_indice returns to 0.
- After the valid frame, send "12A045#" -> erroRecepcao pulses when 'A' completes; valor_reg stays 48'h313233303435; the following "045#" also errors on '#'; no fimRecepcao.
- Send "1230" with the 5th character's stop bit forced to 0, then "987654#" -> one erroRecepcao pulse (db_estado=5 seen); then fimRecepcao with valor_reg=48'h393837363534.
- Drive a 4-cycle low glitch on an idle line -> FSM returns to OCIOSO from START; no pulses; db_indice unchanged.
- Assert reset for 1 cycle after the 3rd character of "555555#", then send "010203#" wait, send "010203#" -> every output is at its reset value on the next cycle; the following full frame "010203#" produces valor_reg=48'h303130323033.
- Send "111111#222222#" back-to-back -> two fimRecepcao pulses, one 7-character time apart; valor_reg ends at 48'h323232323232.
